sd_dac: RTL and testbench
=========================

# sd_dac

First-order sigma-delta DAC: the transmit-side counterpart of the sigma-delta sense (ADC) path. It accepts WIDTH-bit unsigned codes over a valid/ready handshake at a fixed sample rate and produces a 1-bit pulse-density stream on a GPIO pin. An external RC low-pass filter recovers the analog level. It consumes the same 15-bit code format that the sense block produces, so a sensed value can be looped straight back out as an analog level.

## Interface
- WIDTH, 15: code width; output density = code / 2^WIDTH.
- DIV, 48: clocks per sample period; legal range ≥ 2.
- clk  in  1  system clock (48 MHz on board).
- rst  in  1  asynchronous, active-low reset.
- din  in  WIDTH  unsigned sample code.
- din_valid  in  1  din holds a sample.
- din_ready  out  1  block can accept a sample this cycle.
- en  in  1  modulator enable; when low, output is forced low.
- dac_out  out  1  registered pulse-density output to the pin.
- sample_tick  out  1  one-cycle pulse on the last clock of each sample period.
- underrun  out  1  one-cycle pulse when a period boundary finds no pending sample.

## Operation
- Storage:
  - pend register plus pend_v flag: one-deep input buffer.
  - active register: the code currently being modulated.
  - acc: WIDTH-bit accumulator.
  - cnt: period counter, 0..DIV-1.
- Handshake:
  - din_ready = ~pend_v, driven directly from the register with no combinational path from din_valid.
  - A transfer occurs on a rising edge where din_valid && din_ready; pend ← din and pend_v ← 1.
  - din is ignored when no transfer occurs.
- Period counter:
  - cnt increments every clock and wraps from DIV-1 to 0.
  - sample_tick = (cnt == DIV-1).
  - The counter runs regardless of en.
- Boundary (cycle with sample_tick = 1):
  - If pend_v: active ← pend and pend_v ← 0.
  - Else: active is held and underrun pulses for that cycle.
- Simultaneous boundary and valid input: din_ready is 0 whenever pend_v = 1, so no transfer takes place that cycle. The sample is accepted on the next edge, because ready goes high in the cycle after the boundary.
- Modulator, evaluated every clock while en = 1:
  - {carry, sum} = acc + active, computed WIDTH+1 bits wide.
  - acc ← sum; dac_out ← carry.
  - Arithmetic is modulo 2^WIDTH on acc, and the carry is the output bit.
- en = 0:
  - acc ← 0 and dac_out ← 0.
  - The handshake and period logic keep running.
  - The first carry after en rises therefore starts from acc = 0.
- Code 0 yields constant 0. Code 2^WIDTH-1 yields 1 on all but one clock in 2^WIDTH. Full-on is intentionally unreachable.

## Timing
- Reset values:
  - dac_out 0, sample_tick 0, underrun 0.
  - din_ready 1 (pend_v 0).
  - acc 0, active 0, cnt 0.
- Reset assertion clears all state immediately, with no clock required, including in mid-period or with a pending sample. The pending sample is discarded.
- After release, the first sample_tick occurs on the DIV-th clock edge.
- Latency from transfer to effect:
  - The sample sits in pend until the next boundary.
  - active updates on the edge ending the boundary cycle.
  - The new code affects dac_out from the following edge onward, so the output reflects it 1 clock after active changes.
- Throughput is one sample per DIV clocks. A source that is always valid never sees underrun after the first period.
- At most one transfer is accepted per period beyond the one in pend. The second transfer stalls, with din_ready low, until the boundary.

## Test plan
- Reset: assert rst=0 mid-run with pend_v=1 and dac_out=1 → all outputs go to their reset values asynchronously. After release, sample_tick first pulses on edge DIV. Use DIV=4 for all scenarios here.
- Code 0 and code 16384 (WIDTH=15):
  - Code 0 → dac_out constant 0.
  - Code 16384 → from the boundary onward dac_out toggles 0,1,0,1, giving exactly 512 ones in 1024 clocks.
- Code 1 with en=1 held → exactly one dac_out=1 per 32768 clocks, first at clock 32768 after active loads. Code 32767 → exactly one 0 per 32768 clocks.
- Handshake: drive din_valid=1 with codes A,B,C back-to-back →
  - A accepted immediately and B stalls with din_ready=0.
  - A becomes active at boundary 1, and B is accepted the next cycle.
  - No sample is lost or duplicated.
- Underrun: load 8192, then drop din_valid for 3 periods → underrun pulses at each of the 3 boundaries, active stays 8192, and dac_out density holds at 1/4.
- Enable: en=0 for 10 clocks mid-run → dac_out 0 throughout. After en returns high, the output pattern restarts from acc=0, and cnt/sample_tick spacing is unaffected.

Source files
------------

// File: rtl/sd_dac.sv
// First-order sigma-delta DAC: WIDTH-bit codes in over valid/ready, one code per DIV-clock
// period, 1-bit pulse-density stream out. Density = code / 2^WIDTH.
module sd_dac #(
  parameter int WIDTH = 15,
  parameter int DIV   = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             dac_out,
  output logic             sample_tick,
  output logic             underrun
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend, active, acc;
  logic             pend_v;
  logic [WIDTH:0]   sum;

  assign din_ready   = ~pend_v;
  assign sample_tick = (cnt == CNT_MAX);
  assign underrun    = sample_tick & ~pend_v;
  assign sum         = {1'b0, acc} + {1'b0, active};

  // Period counter free-runs independent of en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (sample_tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // One-deep buffer; a boundary with nothing pending still lets a new sample in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= '0;
      pend_v <= 1'b0;
      active <= '0;
    end else if (sample_tick && pend_v) begin
      active <= pend;
      pend_v <= 1'b0;
    end else if (din_valid && !pend_v) begin
      pend   <= din;
      pend_v <= 1'b1;
    end
  end

  // Modulo-2^WIDTH accumulator; carry out is the output bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else if (en) begin
      acc     <= sum[WIDTH-1:0];
      dac_out <= sum[WIDTH];
    end else begin
      acc     <= '0;
      dac_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sd_dac.sv
// Directed bench for sd_dac (WIDTH=15, DIV=4) with hand-computed expectations.
module tb_sd_dac;
  localparam int W = 15;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         en = 1'b0;
  logic         din_ready, dac_out, sample_tick, underrun;

  sd_dac #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .en(en), .dac_out(dac_out), .sample_tick(sample_tick), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, last_tick = -1, gap_bad = 0;
  logic [W-1:0] xq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, track tick spacing
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sample_tick) begin
      if (last_tick >= 0 && cyc - last_tick != D) gap_bad++;
      last_tick = cyc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_tick = -1;
  endtask

  task automatic send(input logic [W-1:0] code);
    din = code;
    din_valid = 1'b1;
    for (int i = 0; i < 4 * D; i++) begin
      if (din_ready) break;
      step();
    end
    chk("send_ready", din_ready, 1);
    step();
    din_valid = 1'b0;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * D; i++) begin
      if (sample_tick) break;
      step();
    end
    chk("tick_wait", sample_tick, 1);
  endtask

  always @(posedge clk)
    if (rst && din_valid && din_ready) xq.push_back(din);

  initial begin
    logic [3:0] tv, uv, pat;
    int ones, zeros, first, udr, tks;

    // reset state
    #2;
    chk("rst_dac", dac_out, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_udr", underrun, 0);
    chk("rst_ready", din_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    en = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      tv[e] = sample_tick;
      uv[e] = underrun;
    end
    chk("first_tick", tv, 4'b0100);
    chk("first_udr", uv, 4'b0100);

    // code 16384: alternating from acc=0
    send(W'(16384));
    wait_tick();
    step();
    ones = 0; pat = '0;
    for (int k = 1; k <= 1024; k++) begin
      step();
      ones += int'(dac_out);
      if (k <= 4) pat[k-1] = dac_out;
    end
    chk("half_pat", pat, 4'b1010);
    chk("half_ones", ones, 512);

    // code 0
    send(W'(0));
    wait_tick();
    step();
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      ones += int'(dac_out);
    end
    chk("zero_ones", ones, 0);

    // code 1 from acc=0
    do_reset();
    send(W'(1));
    wait_tick();
    step();
    ones = 0; first = 0;
    for (int k = 1; k <= 32768; k++) begin
      step();
      if (dac_out) begin
        ones++;
        if (first == 0) first = k;
      end
    end
    chk("one_first", first, 32768);
    chk("one_ones", ones, 1);

    // code 32767
    send(W'(32767));
    wait_tick();
    step();
    zeros = 0;
    for (int k = 0; k < 32768; k++) begin
      step();
      zeros += int'(!dac_out);
    end
    chk("max_zeros", zeros, 1);

    // handshake A,B,C back to back
    do_reset();
    xq.delete();
    din = W'(16384); din_valid = 1'b1;
    step();                                  // edge1: A accepted
    chk("hs_a_stall", din_ready, 0);
    din = W'(1000);
    step(); step();                          // edge3: boundary cycle
    chk("hs_b_stall", din_ready, 0);
    chk("hs_tick", sample_tick, 1);
    step();                                  // edge4: A -> active
    chk("hs_ready", din_ready, 1);
    step();                                  // edge5: B accepted
    chk("hs_b_taken", din_ready, 0);
    pat[0] = dac_out;
    din = W'(2000);
    step();
    pat[1] = dac_out;
    chk("hs_a_active", pat[1:0], 2'b10);
    for (int i = 0; i < 3 * D; i++) begin
      if (din_ready) break;
      step();
    end
    step();                                  // C accepted
    din_valid = 1'b0;
    step();
    chk("hs_count", xq.size(), 3);
    if (xq.size() == 3) begin
      chk("hs_x0", xq[0], 16384);
      chk("hs_x1", xq[1], 1000);
      chk("hs_x2", xq[2], 2000);
    end

    // underrun: 8192 then no input for 3 periods
    do_reset();
    send(W'(8192));
    wait_tick();
    chk("udr_none", underrun, 0);
    step();
    ones = 0; udr = 0; tks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      ones += int'(dac_out);
      udr += int'(underrun);
      tks += int'(sample_tick);
    end
    chk("udr_pulses", udr, 3);
    chk("udr_ticks", tks, 3);
    chk("udr_ones", ones, 3);

    // enable drop mid-run, acc left nonzero beforehand
    step();
    en = 1'b0;
    ones = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      ones += int'(dac_out);
    end
    chk("en_off", ones, 0);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      pat[k] = dac_out;
    end
    chk("en_restart", pat, 4'b1000);
    for (int k = 0; k < 8; k++) step();
    chk("tick_gap", gap_bad, 0);

    // async reset mid-period with pending sample and dac_out high
    send(W'(16384));
    wait_tick();
    step();
    din = W'(5); din_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dac_out && !din_ready) break;
    end
    chk("pre_rst", {dac_out, din_ready}, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dac", dac_out, 0);
    chk("arst_ready", din_ready, 1);
    chk("arst_tick", sample_tick, 0);
    chk("arst_udr", underrun, 0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_tick = -1;
    for (int e = 0; e < 4; e++) begin
      step();
      tv[e] = sample_tick;
      uv[e] = underrun;
    end
    chk("re_tick", tv, 4'b0100);
    chk("re_udr", uv, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
